// File: rtl/ultra_net_mac_pkg.sv
// Shared width defaults and constant helpers for the multi-lane MAC engine.
package ultra_net_mac_pkg;

    localparam int DEF_A_WIDTH   = 12;
    localparam int DEF_B_WIDTH   = 16;
    localparam int DEF_LANES     = 4;
    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_SAT       = 1;

    // Unsigned activation gets a zero sign bit, so the product needs one extra bit.
    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w + 1;
    endfunction

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/ultra_net_mac_lane.sv
// One MAC lane: operand register, product register, accumulator and result register.
module ultra_net_mac_lane
    import ultra_net_mac_pkg::*;
#(
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int B_WIDTH   = DEF_B_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int SAT       = DEF_SAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        adv,
    input  logic                        vld_p1,
    input  logic                        last_p1,
    input  logic        [A_WIDTH-1:0]   a,
    input  logic signed [B_WIDTH-1:0]   b,
    output logic signed [ACC_WIDTH-1:0] res,
    output logic                        sat
);

    localparam int PW = prod_width(A_WIDTH, B_WIDTH);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

    // Returns {overflow_flag, value}; the flag is only raised when clamping is enabled.
    function automatic logic [ACC_WIDTH:0] acc_add(input logic signed [ACC_WIDTH-1:0] x,
                                                   input logic signed [ACC_WIDTH-1:0] y);
        logic signed [ACC_WIDTH:0] s;
        s = {x[ACC_WIDTH-1], x} + {y[ACC_WIDTH-1], y};
        if ((s[ACC_WIDTH] != s[ACC_WIDTH-1]) && (SAT != 0))
            return {1'b1, (s[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
        return {1'b0, s[ACC_WIDTH-1:0]};
    endfunction

    logic        [A_WIDTH-1:0]   a_p0;
    logic signed [B_WIDTH-1:0]   b_p0;
    logic signed [PW-1:0]        a_ext;
    logic signed [PW-1:0]        b_ext;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        prod_p1;
    logic signed [ACC_WIDTH-1:0] p_ext;
    logic        [ACC_WIDTH:0]   add_p2;
    logic signed [ACC_WIDTH-1:0] sum_p2;
    logic                        ovf_p2;
    logic signed [ACC_WIDTH-1:0] acc_p2;
    logic                        sticky_p2;

    assign a_ext  = PW'(signed'({1'b0, a_p0}));
    assign b_ext  = PW'(b_p0);
    assign prod   = a_ext * b_ext;
    assign p_ext  = ACC_WIDTH'(prod_p1);
    assign add_p2 = acc_add(acc_p2, p_ext);
    assign sum_p2 = add_p2[ACC_WIDTH-1:0];
    assign ovf_p2 = add_p2[ACC_WIDTH];

    // S1 operand capture and S2 product; validity is tracked by the shared control.
    always_ff @(posedge clk) begin
        if (adv) begin
            a_p0    <= a;
            b_p0    <= b;
            prod_p1 <= prod;
        end
    end

    // S3: accumulate; a closing beat loads the result and restarts the group from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p2    <= '0;
            sticky_p2 <= 1'b0;
            res       <= '0;
            sat       <= 1'b0;
        end else if (adv && vld_p1) begin
            if (last_p1) begin
                res       <= sum_p2;
                sat       <= sticky_p2 | ovf_p2;
                acc_p2    <= '0;
                sticky_p2 <= 1'b0;
            end else begin
                acc_p2    <= sum_p2;
                sticky_p2 <= sticky_p2 | ovf_p2;
            end
        end
    end

endmodule

// File: rtl/ultra_net_mac_pipe.sv
// Multi-lane pipelined MAC with shared valid/ready control and per-lane datapaths.
module ultra_net_mac_pipe
    import ultra_net_mac_pkg::*;
#(
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int B_WIDTH   = DEF_B_WIDTH,
    parameter int LANES     = DEF_LANES,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int SAT       = DEF_SAT
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*A_WIDTH-1:0]     in_a,
    input  logic [LANES*B_WIDTH-1:0]     in_b,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ACC_WIDTH-1:0]   out_acc,
    output logic [LANES-1:0]             out_sat
);

    logic adv;
    logic take;
    logic vld_p0;
    logic last_p0;
    logic vld_p1;
    logic last_p1;

    // The whole pipe moves as one; a held result freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign take     = in_valid && adv;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            vld_p0    <= 1'b0;
            last_p0   <= 1'b0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            vld_p0    <= take;
            last_p0   <= in_last;
            vld_p1    <= vld_p0;
            last_p1   <= last_p0;
            out_valid <= vld_p1 && last_p1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ultra_net_mac_lane #(
            .A_WIDTH   (A_WIDTH),
            .B_WIDTH   (B_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .SAT       (SAT)
        ) u_lane (
            .clk     (ap_clk),
            .rst     (ap_rst),
            .adv     (adv),
            .vld_p1  (vld_p1),
            .last_p1 (last_p1),
            .a       (in_a[i*A_WIDTH +: A_WIDTH]),
            .b       (in_b[i*B_WIDTH +: B_WIDTH]),
            .res     (out_acc[i*ACC_WIDTH +: ACC_WIDTH]),
            .sat     (out_sat[i])
        );
    end

endmodule

// File: doc/ultra_net_mac_pipe.md
Name: ultra_net_mac_pipe

Overview:
Parametrised, pipelined multi-lane multiply-accumulate engine for the conv compute core.
- It is the successor to the single combinational unsigned×signed DSP48 multiplier.
- Each lane multiplies an unsigned activation by a signed weight and accumulates over a group of beats delimited by in_last.
- It has valid/ready handshakes on both sides, full backpressure, and optional saturation.
- It sits between the weight/activation line buffers and the requantisation stage.

Parameters:
A_WIDTH, 12, activation width (unsigned)
B_WIDTH, 16, weight width (two's complement)
LANES, 4, number of independent MAC lanes
ACC_WIDTH, 32, accumulator/result width (signed); must be >= A_WIDTH+B_WIDTH+1
SAT, 1, 1 = saturating accumulate, 0 = two's-complement wrap

Ports:
ap_clk  in  1  clock; all state updates on rising edge
ap_rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_a  in  LANES*A_WIDTH  unsigned activations, lane i at [i*A_WIDTH +: A_WIDTH]
in_b  in  LANES*B_WIDTH  signed weights, lane i at [i*B_WIDTH +: B_WIDTH]
in_last  in  1  beat closes the current accumulation group
out_valid  out  1  result vector valid
out_ready  in  1  downstream accepts the result
out_acc  out  LANES*ACC_WIDTH  signed group sums, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
out_sat  out  LANES  per-lane flag, set if saturation occurred anywhere in the group (always 0 when SAT=0)

Behaviour:
- Reset (async, any time, including mid-group): all pipeline valids, accumulators, out_valid, out_acc and out_sat go to 0. in_ready goes to 1 once ap_rst is released. A partial group is discarded.
- Transfer occurs when in_valid && in_ready. Results are taken when out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. All stages move only when adv=1; stalled stages hold their contents.
- Stage S1: register in_a, in_b, in_last, valid.
- Stage S2: product p = signed({1'b0,a}) * signed(b), width A_WIDTH+B_WIDTH+1, registered.
- Stage S3: accumulate and load output.
  - Sign-extend p to ACC_WIDTH.
  - Sum: acc_next = acc + p, computed at ACC_WIDTH+1 bits.
  - SAT=1: per beat, clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and set that lane's sticky sat bit.
  - SAT=0: truncate (wrap).
- Last beat at S3: out_acc <= acc_next, out_sat <= sticky|this-beat overflow, out_valid <= 1. The accumulator and sticky bits clear to 0 for the next group in the same cycle.
- Non-last beat at S3: the accumulator updates and out_valid is unchanged by this beat.
- Latency: a last beat accepted in cycle T gives out_valid=1 in cycle T+3 when unstalled. Throughput is one beat per cycle.
- A group of length 1 (in_last on every beat) yields one result per cycle.
- Stall: when out_valid=1 and out_ready=0, the whole pipe freezes. There is no data loss and no duplicate output. out_acc and out_sat stay stable while out_valid is held.
- Simultaneous out handshake and new last arriving at S3: the output register reloads in the same cycle and out_valid stays 1.
- in_valid=0 bubbles propagate and do not touch the accumulators.

Decomposition:
- Package ultra_net_mac_pkg holds:
  - default width constants;
  - a function computing the product width;
  - functions for the saturation min/max constants.
- One sub-module, ultra_net_mac_lane, contains the S1–S3 datapath and accumulator for one lane. It is instantiated LANES times.
- Handshake and valid/last control are shared in the top level.

Test Plan:
- Single beat, lane0 a=4095, b=-32768, last=1 -> out_acc lane0 = -134184960 at T+3, out_sat=0.
- Lane0 group of 3 beats (a,b) = (10,-3), (7,5), (1,1) with last on beat 3 -> lane0 out_acc = 6; the next group starts from 0.
- ACC_WIDTH=29, SAT=1, 3 beats a=4095, b=32767 -> 268435455 and out_sat=1. With SAT=0 -> -134328317 and out_sat=0.
- out_ready held 0 for 5 cycles with last every beat -> in_ready=0 while stalled, out_acc stable, every group delivered exactly once and in order after release.
- ap_rst pulsed mid-group after 2 beats -> outputs 0 immediately. The next group (2,3),(4,-1) with last -> 2, not including pre-reset beats.
- LANES=4, distinct per-lane values, random in_valid/out_ready -> each lane's results match the reference model sum-per-group.
